gray_to_rgb: RTL and testbench

- Converts a stream of grayscale pixels back to RGB for the VGA/display path, so tracking masks and intensity maps can be viewed.
- Two maps, selected per pixel: monochrome (gray replicated to R, G and B) and a 4-segment "heat" false-colour map.
- Two-stage pipeline with valid/ready backpressure on both sides.
- Carries start-of-frame and end-of-frame flags alongside each pixel.

---
 rtl/gray_to_rgb_pkg.sv | 15 +
 rtl/gray_to_rgb_if.sv | 37 +++
 rtl/gray_heat_map.sv | 50 +++++
 rtl/gray_to_rgb.sv | 108 ++++++++++
 tb/tb_gray_to_rgb.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gray_to_rgb_pkg.sv
// Shared video definitions for the gray-to-RGB display path.
// Holds the default channel width, map-select codes and full-scale helper.
package gray_to_rgb_pkg;

    localparam int RGB_WIDTH = 10;

    localparam logic MAP_MONO = 1'b0;
    localparam logic MAP_HEAT = 1'b1;

    // Full-scale channel value M = 2^w - 1.
    function automatic int unsigned max_of(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/gray_to_rgb_if.sv
// Pixel stream bundle: gray input side and RGB output side with handshakes.
// slave = converter side, master = producer/consumer side.
interface gray_to_rgb_if
    import gray_to_rgb_pkg::*;
#(
    parameter int rgb_width = RGB_WIDTH
) ();

    logic [rgb_width-1:0] GRAYSCALE;
    logic                 heat_sel;
    logic                 sop_in;
    logic                 eop_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [rgb_width-1:0] RED;
    logic [rgb_width-1:0] GREEN;
    logic [rgb_width-1:0] BLUE;
    logic                 sop_out;
    logic                 eop_out;
    logic                 out_valid;
    logic                 out_ready;

    modport slave (
        input  GRAYSCALE, heat_sel, sop_in, eop_in,
        input  in_valid, out_ready,
        output in_ready, RED, GREEN, BLUE,
        output sop_out, eop_out, out_valid
    );

    modport master (
        output GRAYSCALE, heat_sel, sop_in, eop_in,
        output in_valid, out_ready,
        input  in_ready, RED, GREEN, BLUE,
        input  sop_out, eop_out, out_valid
    );

endinterface

// File: rtl/gray_heat_map.sv
// Combinational 4-segment false-colour map: blue->cyan->green->yellow->red.
// Ports: g (gray in), red/green/blue (mapped channels).
module gray_heat_map
    import gray_to_rgb_pkg::*;
#(
    parameter int rgb_width = RGB_WIDTH
) (
    input  logic [rgb_width-1:0] g,
    output logic [rgb_width-1:0] red,
    output logic [rgb_width-1:0] green,
    output logic [rgb_width-1:0] blue
);

    localparam logic [rgb_width-1:0] M =
        rgb_width'(max_of(rgb_width));

    logic [1:0]           q;
    logic [rgb_width-3:0] f;
    logic [rgb_width-1:0] s;

    assign q = g[rgb_width-1 -: 2];
    assign f = g[rgb_width-3:0];
    // Replicate the top two fraction bits so s reaches full scale.
    assign s = {f, f[rgb_width-3 -: 2]};

    always_comb begin
        red   = '0;
        green = '0;
        blue  = '0;
        unique case (q)
            2'd0: begin
                green = s;
                blue  = M;
            end
            2'd1: begin
                green = M;
                blue  = M - s;
            end
            2'd2: begin
                red   = s;
                green = M;
            end
            2'd3: begin
                red   = M;
                green = M - s;
            end
        endcase
    end

endmodule

// File: rtl/gray_to_rgb.sv
// Two-stage gray-to-RGB converter with valid/ready on both sides.
// Ports: clk, reset (sync, active high), bus (pixel stream, slave side).
module gray_to_rgb
    import gray_to_rgb_pkg::*;
#(
    parameter int rgb_width = RGB_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    gray_to_rgb_if.slave  bus
);

    logic                 v1;
    logic [rgb_width-1:0] g1;
    logic                 heat1;
    logic                 sop1;
    logic                 eop1;

    logic                 v2;
    logic [rgb_width-1:0] red_q;
    logic [rgb_width-1:0] green_q;
    logic [rgb_width-1:0] blue_q;
    logic                 sop_q;
    logic                 eop_q;

    logic                 adv1;
    logic                 adv2;
    logic                 in_fire;

    logic [rgb_width-1:0] hm_r;
    logic [rgb_width-1:0] hm_g;
    logic [rgb_width-1:0] hm_b;
    logic [rgb_width-1:0] map_r;
    logic [rgb_width-1:0] map_g;
    logic [rgb_width-1:0] map_b;

    // Ready ripples back combinationally from out_ready.
    assign adv2    = !v2 || bus.out_ready;
    assign adv1    = !v1 || adv2;
    assign in_fire = bus.in_valid && adv1;

    gray_heat_map #(
        .rgb_width(rgb_width)
    ) u_heat (
        .g    (g1),
        .red  (hm_r),
        .green(hm_g),
        .blue (hm_b)
    );

    always_comb begin
        map_r = g1;
        map_g = g1;
        map_b = g1;
        if (heat1 == MAP_HEAT) begin
            map_r = hm_r;
            map_g = hm_g;
            map_b = hm_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1    <= 1'b0;
            g1    <= '0;
            heat1 <= MAP_MONO;
            sop1  <= 1'b0;
            eop1  <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_fire;
            end
            if (in_fire) begin
                g1    <= bus.GRAYSCALE;
                heat1 <= bus.heat_sel;
                sop1  <= bus.sop_in;
                eop1  <= bus.eop_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2      <= 1'b0;
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else if (adv2) begin
            v2      <= v1;
            red_q   <= map_r;
            green_q <= map_g;
            blue_q  <= map_b;
            sop_q   <= sop1;
            eop_q   <= eop1;
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2;
    assign bus.RED       = red_q;
    assign bus.GREEN     = green_q;
    assign bus.BLUE      = blue_q;
    assign bus.sop_out   = sop_q;
    assign bus.eop_out   = eop_q;

endmodule

// File: tb/tb_gray_to_rgb.sv
// Directed self-checking bench for gray_to_rgb and gray_heat_map.
// Drives after posedge, samples at negedge.
module tb_gray_to_rgb;
    import gray_to_rgb_pkg::*;

    localparam int W = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;

    int errors = 0;
    int checks = 0;

    gray_to_rgb_if #(.rgb_width(W)) bus ();

    gray_to_rgb #(
        .rgb_width(W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [W-1:0] hm_in;
    logic [W-1:0] hm_r;
    logic [W-1:0] hm_g;
    logic [W-1:0] hm_b;

    gray_heat_map #(
        .rgb_width(W)
    ) u_hm (
        .g    (hm_in),
        .red  (hm_r),
        .green(hm_g),
        .blue (hm_b)
    );

    always #5 clk = ~clk;

    logic [W-1:0] h_g [6] = '{10'd0, 10'd255, 10'd256,
                              10'd512, 10'd640, 10'd1023};
    logic [W-1:0] h_r [6] = '{10'd0, 10'd0, 10'd0,
                              10'd0, 10'd514, 10'd1023};
    logic [W-1:0] h_gr[6] = '{10'd0, 10'd1023, 10'd1023,
                              10'd1023, 10'd1023, 10'd0};
    logic [W-1:0] h_b [6] = '{10'd1023, 10'd1023, 10'd1023,
                              10'd0, 10'd0, 10'd0};

    logic [W-1:0] sdata[8];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int n,
                              input logic [15:0] pat,
                              input string name);
        int sent;
        int rcv;
        int occ;
        logic stall_prev;
        logic [W-1:0] pr;
        logic [W-1:0] pg;
        logic [W-1:0] pb;
        logic ps;
        logic pe;
        sent = 0;
        rcv = 0;
        stall_prev = 1'b0;
        pr = '0;
        pg = '0;
        pb = '0;
        ps = 1'b0;
        pe = 1'b0;
        for (int cyc = 0; cyc < 80 && rcv < n; cyc++) begin
            bus.in_valid  = (sent < n);
            bus.GRAYSCALE = (sent < n) ? sdata[sent] : '0;
            bus.sop_in    = (sent == 0);
            bus.eop_in    = (sent == n - 1);
            bus.heat_sel  = MAP_MONO;
            bus.out_ready = pat[cyc % 16];
            @(negedge clk);
            occ = sent - rcv;
            chk({name, "_in_ready"}, 32'(bus.in_ready),
                32'(!(occ == 2 && !bus.out_ready)));
            if (stall_prev) begin
                chk({name, "_hold_v"}, 32'(bus.out_valid), 1);
                chk({name, "_hold_r"}, 32'(bus.RED), 32'(pr));
                chk({name, "_hold_g"}, 32'(bus.GREEN), 32'(pg));
                chk({name, "_hold_b"}, 32'(bus.BLUE), 32'(pb));
                chk({name, "_hold_sop"}, 32'(bus.sop_out), 32'(ps));
                chk({name, "_hold_eop"}, 32'(bus.eop_out), 32'(pe));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk({name, "_r"}, 32'(bus.RED), 32'(sdata[rcv]));
                chk({name, "_g"}, 32'(bus.GREEN), 32'(sdata[rcv]));
                chk({name, "_b"}, 32'(bus.BLUE), 32'(sdata[rcv]));
                chk({name, "_sop"}, 32'(bus.sop_out),
                    32'(rcv == 0));
                chk({name, "_eop"}, 32'(bus.eop_out),
                    32'(rcv == n - 1));
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sent++;
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            pr = bus.RED;
            pg = bus.GREEN;
            pb = bus.BLUE;
            ps = bus.sop_out;
            pe = bus.eop_out;
            step();
        end
        chk({name, "_count"}, 32'(rcv), 32'(n));
        bus.in_valid  = 1'b0;
        bus.sop_in    = 1'b0;
        bus.eop_in    = 1'b0;
        bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk({name, "_drained"}, 32'(bus.out_valid), 0);
        step();
    endtask

    initial begin
        bus.GRAYSCALE = '0;
        bus.heat_sel  = MAP_MONO;
        bus.sop_in    = 1'b0;
        bus.eop_in    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        hm_in         = '0;

        // Standalone map: ends and mid-segment points.
        hm_in = 10'd0;
        #1;
        chk("hm0_r", 32'(hm_r), 0);
        chk("hm0_g", 32'(hm_g), 0);
        chk("hm0_b", 32'(hm_b), 1023);
        hm_in = 10'd1023;
        #1;
        chk("hmM_r", 32'(hm_r), 1023);
        chk("hmM_g", 32'(hm_g), 0);
        chk("hmM_b", 32'(hm_b), 0);
        hm_in = 10'd127;
        #1;
        chk("hm127_r", 32'(hm_r), 0);
        chk("hm127_g", 32'(hm_g), 509);
        chk("hm127_b", 32'(hm_b), 1023);
        hm_in = 10'd383;
        #1;
        chk("hm383_r", 32'(hm_r), 0);
        chk("hm383_g", 32'(hm_g), 1023);
        chk("hm383_b", 32'(hm_b), 514);
        hm_in = 10'd895;
        #1;
        chk("hm895_r", 32'(hm_r), 1023);
        chk("hm895_g", 32'(hm_g), 514);
        chk("hm895_b", 32'(hm_b), 0);

        // Reset state, out_ready low.
        repeat (2) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_r", 32'(bus.RED), 0);
        chk("rst_g", 32'(bus.GREEN), 0);
        chk("rst_b", 32'(bus.BLUE), 0);
        chk("rst_sop", 32'(bus.sop_out), 0);
        chk("rst_eop", 32'(bus.eop_out), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        step();

        // Mono single pulse, 2-cycle latency.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.GRAYSCALE = 10'd300;
        bus.heat_sel  = MAP_MONO;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mono_lat1", 32'(bus.out_valid), 0);
        step();
        @(negedge clk);
        chk("mono_valid", 32'(bus.out_valid), 1);
        chk("mono_r", 32'(bus.RED), 300);
        chk("mono_g", 32'(bus.GREEN), 300);
        chk("mono_b", 32'(bus.BLUE), 300);
        step();
        @(negedge clk);
        chk("mono_once", 32'(bus.out_valid), 0);
        step();

        // Heat stream, one pixel per cycle.
        for (int i = 0; i < 8; i++) begin
            bus.in_valid  = (i < 6);
            bus.GRAYSCALE = (i < 6) ? h_g[i] : '0;
            bus.heat_sel  = MAP_HEAT;
            @(negedge clk);
            if (i >= 2) begin
                chk("heat_v", 32'(bus.out_valid), 1);
                chk("heat_r", 32'(bus.RED), 32'(h_r[i-2]));
                chk("heat_g", 32'(bus.GREEN), 32'(h_gr[i-2]));
                chk("heat_b", 32'(bus.BLUE), 32'(h_b[i-2]));
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.heat_sel = MAP_MONO;
        repeat (2) step();

        // Backpressure stream of 8.
        sdata = '{10'd11, 10'd222, 10'd333, 10'd44,
                  10'd555, 10'd666, 10'd7, 10'd1023};
        run_stream(8, 16'b1011_0010_0110_1001, "bp");

        // 4-pixel frame with stalls.
        sdata[0] = 10'd90;
        sdata[1] = 10'd91;
        sdata[2] = 10'd92;
        sdata[3] = 10'd93;
        run_stream(4, 16'b0110_0100_1100_0101, "frm");

        // Reset with both stages full and stalled.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.GRAYSCALE = 10'd100;
        step();
        bus.GRAYSCALE = 10'd200;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_valid", 32'(bus.out_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 32'(bus.out_valid), 0);
        chk("mrst_r", 32'(bus.RED), 0);
        chk("mrst_g", 32'(bus.GREEN), 0);
        chk("mrst_b", 32'(bus.BLUE), 0);
        chk("mrst_in_ready", 32'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.GRAYSCALE = 10'd77;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_lat1", 32'(bus.out_valid), 0);
        step();
        @(negedge clk);
        chk("mrst_out_v", 32'(bus.out_valid), 1);
        chk("mrst_out_r", 32'(bus.RED), 77);
        step();
        @(negedge clk);
        chk("mrst_once", 32'(bus.out_valid), 0);
        step();

        // Per-pixel map switch at g=512.
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = (i < 4);
            bus.GRAYSCALE = 10'd512;
            bus.heat_sel  = i[0] ? MAP_HEAT : MAP_MONO;
            @(negedge clk);
            if (i >= 2) begin
                chk("sw_v", 32'(bus.out_valid), 1);
                chk("sw_r", 32'(bus.RED),
                    i[0] ? 32'd0 : 32'd512);
                chk("sw_g", 32'(bus.GREEN),
                    i[0] ? 32'd1023 : 32'd512);
                chk("sw_b", 32'(bus.BLUE),
                    i[0] ? 32'd0 : 32'd512);
            end
            step();
        end
        bus.in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
